mc_core: RTL
============

MC_CORE -- requirements
Module: mc_core

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the datapath and register width (minimum 9).
REQ-002 The block SHALL have parameter PC_W, default 32, giving the program counter and instruction address width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port imem_req, output, 1 bit, instruction fetch request.
REQ-006 The block SHALL have port imem_addr, output, PC_W bits, byte address of the fetch, equal to PC.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits, instruction word, valid when imem_ack=1.
REQ-008 The block SHALL have port imem_ack, input, 1 bit, fetch completion strobe.
REQ-009 The block SHALL have port SW, input, DATA_W bits, external input operand.
REQ-010 The block SHALL have port sw_valid, input, 1 bit, SW holds valid data.
REQ-011 The block SHALL have port HEX, output, DATA_W bits, registered display value.
REQ-012 The block SHALL have port halted, output, 1 bit, high while in HALT.

Function
REQ-013 Instruction fields SHALL be: [31] jump, [30] branch, [29] write enable, [28:27] write source (00 const, 01 SW, 10 ALU, 11 halt), [26:23] ALU op, [22:18] A1, [17:13] A2, [12:8] A3, [7:0] const.
REQ-014 The const SHALL be sign-extended from bit 7 to DATA_W for write-back and to PC_W for the offset.
REQ-015 The register file SHALL hold 32 x DATA_W entries, two combinational read ports and one write port; register 0 SHALL read as zero and ignore writes.
REQ-016 ALU ops SHALL be: 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and; shifts use RD2[4:0]; others yield 0.
REQ-017 The comparison flag SHALL be: op 1100 eq, 1101 ne, 1110 signed lt, 1111 signed ge, otherwise 0.
REQ-018 The FSM SHALL have states FETCH, EXEC, WB, HALT.
REQ-019 FETCH: imem_req=1; on imem_ack=1 latch imem_rdata into the instruction register and go to EXEC; otherwise stay.
REQ-020 EXEC: latch HEX <= RD1 and compute write data and next PC; go to WB, except write source 11 goes to HALT with no RF or PC update.
REQ-021 WB: write RF[A3] when bit 29=1; update PC; go to FETCH.
REQ-022 Next PC SHALL be PC + (SE << 2) when bit 31=1, or when bit 30=1 and the comparison flag is 1; otherwise PC + 4; arithmetic modulo 2^PC_W.
REQ-023 Minimum latency SHALL be 3 cycles per instruction with imem_ack in the first FETCH cycle; each ack-less FETCH cycle adds one.
REQ-024 HALT SHALL hold all state, keep imem_req=0 and halted=1 until reset.
REQ-025 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-026 Reset SHALL asynchronously force state FETCH, PC=0, HEX=0, halted=0, instruction register=0, and all registers=0.
REQ-027 Reset asserted mid-instruction SHALL abort it with no RF write; fetch restarts at address 0 on the first edge after release.

Configuration
REQ-028 With macro MC_CORE_SW_HANDSHAKE_EN defined, an instruction with write source 01 SHALL stay in EXEC until sw_valid=1 and sample SW in that cycle.
REQ-029 Without MC_CORE_SW_HANDSHAKE_EN, sw_valid SHALL be ignored and SW sampled in the first EXEC cycle.

Verification
REQ-030 Const write: 0x200001F6 (WE, const 0xF6 to r1), ack same cycle -> r1=0xFFFFFFF6 after 3 cycles, PC=4.
REQ-031 ALU add: r1=5, r2=7, add into r3 -> r3=12; a following instruction reading r3 as A1 shows HEX=12.
REQ-032 Branch: eq with r1=r2, const 0x03 at PC=8 -> PC=20; ne with same values -> PC=12.
REQ-033 Jump backward: bit 31, const 0xFF at PC=16 -> PC=12; const 0x80 at PC=0 -> PC wraps to 2^PC_W-512.
REQ-034 Handshake (macro defined): write source 01, sw_valid low 4 cycles, then SW=0xABCD with sw_valid=1 -> core stalls 4 cycles in EXEC, destination register=0xABCD.
REQ-035 Halt and reset: write source 11 -> halted=1, imem_req=0 indefinitely; reset asserted during WB of a write -> no write, PC=0, halted=0.

Source files
------------

// File: rtl/mc_core.sv
// mc_core: multi-cycle core with a FETCH / EXEC / WB / HALT sequencer.
// It has a 32 x DATA_W register file and a 10-op ALU with a comparison flag
// used for branches.
//
// Ports:
//   clk, reset         - clock; asynchronous active-high reset
//   imem_req/addr      - fetch request; byte address equals PC
//   imem_rdata/ack     - instruction word and its completion strobe
//   SW, sw_valid       - external operand (write source 01) and its valid flag
//   HEX                - registered display value (RD1 latched in EXEC)
//   halted             - high while in HALT
//
// Optional feature:
//   MC_CORE_SW_HANDSHAKE_EN - when this macro is defined, an SW-sourced write
//   waits in EXEC until sw_valid=1.
module mc_core #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] SW,
    input  logic              sw_valid,
    output logic [DATA_W-1:0] HEX,
    output logic              halted
);
    typedef enum logic [1:0] {FETCH, EXEC, WB, HALT} state_t;

    state_t            state;
    logic [31:0]       ir;
    logic [PC_W-1:0]   pc, pc_next_q, pc_calc, se_p;
    logic [DATA_W-1:0] rf [32];
    logic [DATA_W-1:0] wdata_q, wdata, rd1, rd2, se_d, alu;
    logic              cmp, sw_ok;

    // Instruction fields
    logic       f_jmp, f_br, f_we;
    logic [1:0] f_ws;
    logic [3:0] f_op;
    logic [4:0] f_a1, f_a2, f_a3, shamt;
    assign f_jmp = ir[31];
    assign f_br  = ir[30];
    assign f_we  = ir[29];
    assign f_ws  = ir[28:27];
    assign f_op  = ir[26:23];
    assign f_a1  = ir[22:18];
    assign f_a2  = ir[17:13];
    assign f_a3  = ir[12:8];

    assign se_d  = {{(DATA_W-8){ir[7]}}, ir[7:0]};
    assign se_p  = {{(PC_W-8){ir[7]}}, ir[7:0]};

    assign rd1   = (f_a1 == 5'd0) ? '0 : rf[f_a1];
    assign rd2   = (f_a2 == 5'd0) ? '0 : rf[f_a2];
    assign shamt = rd2[4:0];

    always_comb begin
        alu = '0;
        case (f_op)
            4'b0000: alu = rd1 + rd2;
            4'b0001: alu = rd1 - rd2;
            4'b0010: alu = rd1 << shamt;
            4'b0011: alu = {{(DATA_W-1){1'b0}}, ($signed(rd1) < $signed(rd2))};
            4'b0100: alu = {{(DATA_W-1){1'b0}}, (rd1 < rd2)};
            4'b0101: alu = rd1 ^ rd2;
            4'b0110: alu = rd1 >> shamt;
            4'b0111: alu = $signed(rd1) >>> shamt;
            4'b1000: alu = rd1 | rd2;
            4'b1001: alu = rd1 & rd2;
            default: alu = '0;
        endcase
    end

    always_comb begin
        cmp = 1'b0;
        case (f_op)
            4'b1100: cmp = (rd1 == rd2);
            4'b1101: cmp = (rd1 != rd2);
            4'b1110: cmp = ($signed(rd1) <  $signed(rd2));
            4'b1111: cmp = ($signed(rd1) >= $signed(rd2));
            default: cmp = 1'b0;
        endcase
    end

    always_comb begin
        wdata = se_d;
        case (f_ws)
            2'b01:   wdata = SW;
            2'b10:   wdata = alu;
            default: wdata = se_d;
        endcase
    end

    // Offset is a word count; the shift makes it a byte offset. Wraps mod 2^PC_W.
    assign pc_calc = (f_jmp || (f_br && cmp)) ? pc + (se_p << 2) : pc + PC_W'(4);

`ifdef MC_CORE_SW_HANDSHAKE_EN
    assign sw_ok = (f_ws != 2'b01) || sw_valid;
`else
    logic unused_sw_valid;
    assign unused_sw_valid = sw_valid;
    assign sw_ok = 1'b1;
`endif

    assign imem_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            imem_req  <= 1'b1;
            halted    <= 1'b0;
            pc        <= '0;
            pc_next_q <= '0;
            HEX       <= '0;
            ir        <= '0;
            wdata_q   <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                FETCH: if (imem_ack) begin
                    ir       <= imem_rdata;
                    imem_req <= 1'b0;
                    state    <= EXEC;
                end
                EXEC: begin
                    HEX <= rd1;
                    if (f_ws == 2'b11) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else if (sw_ok) begin
                        // The SW value is captured here, so it may change during WB.
                        wdata_q   <= wdata;
                        pc_next_q <= pc_calc;
                        state     <= WB;
                    end
                end
                WB: begin
                    if (f_we && f_a3 != 5'd0) rf[f_a3] <= wdata_q;
                    pc       <= pc_next_q;
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end
                HALT: ;
                default: state <= FETCH;
            endcase
        end
    end
endmodule
